// File: rtl/aes_word_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_word_packer_pkg                                                  |
// | Shared widths and status typedef for the AES word packer.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_word_packer_pkg;

  localparam int c_IN_WIDTH  = 32;
  localparam int c_OUT_WIDTH = 128;
  localparam int c_CNT_WIDTH = 16;

  typedef struct packed {
    logic [c_CNT_WIDTH-1:0] blk_cnt;
    logic                   done;
    logic                   strb_err;
  } packer_flags_t;

endpackage
`default_nettype wire

// File: rtl/aes_word_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_word_packer_if                                                   |
// | Beat-in / block-out handshake bundle plus job control and status.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface aes_word_packer_if
  import aes_word_packer_pkg::*;
#(
  parameter int IN_WIDTH  = c_IN_WIDTH,
  parameter int OUT_WIDTH = c_OUT_WIDTH,
  parameter int CNT_WIDTH = c_CNT_WIDTH
);

  logic                    clear_i;
  logic                    enable_i;
  logic [CNT_WIDTH-1:0]    len_i;
  logic [IN_WIDTH-1:0]     in_data_i;
  logic [IN_WIDTH/8-1:0]   in_strb_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [OUT_WIDTH-1:0]    out_data_o;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [CNT_WIDTH-1:0]    blk_cnt_o;
  logic                    done_o;
  logic                    strb_err_o;

  modport slave (
    input  clear_i, enable_i, len_i, in_data_i, in_strb_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, blk_cnt_o, done_o, strb_err_o
  );

  modport master (
    output clear_i, enable_i, len_i, in_data_i, in_strb_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, blk_cnt_o, done_o, strb_err_o
  );

endinterface
`default_nettype wire

// File: rtl/aes_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_word_packer                                                      |
// | Packs IN_WIDTH beats (LSW first) into OUT_WIDTH AES blocks.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_word_packer
  import aes_word_packer_pkg::*;
#(
  parameter int IN_WIDTH  = c_IN_WIDTH,
  parameter int OUT_WIDTH = c_OUT_WIDTH,
  parameter int CNT_WIDTH = c_CNT_WIDTH
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  aes_word_packer_if.slave  bus
);

  localparam int c_BEATS = OUT_WIDTH / IN_WIDTH;
  localparam int c_BCW   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam logic [c_BCW-1:0] c_LAST = c_BCW'(c_BEATS - 1);

  logic [c_BCW-1:0]     r_beat_cnt;
  logic [OUT_WIDTH-1:0] r_asm;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_valid;
  logic [CNT_WIDTH-1:0] r_blk_cnt;
  logic                 r_done;
  logic                 r_strb_err;

  logic [OUT_WIDTH-1:0] w_block;
  logic [CNT_WIDTH-1:0] w_blk_next;
  logic                 w_last;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_xfer;
  logic                 w_done_hit;

  // The final beat is only refused when the output slot is full and not draining.
  assign w_last     = (r_beat_cnt == c_LAST);
  assign w_in_ready = bus.enable_i & ~r_done & ~(w_last & r_out_valid & ~bus.out_ready_i);
  assign w_accept   = bus.in_valid_i & w_in_ready;
  assign w_xfer     = r_out_valid & bus.enable_i & bus.out_ready_i;
  assign w_blk_next = r_blk_cnt + CNT_WIDTH'(1);
  assign w_done_hit = (bus.len_i != '0) && (w_blk_next == bus.len_i);

  always_comb begin
    w_block = r_asm;
    w_block[int'(r_beat_cnt) * IN_WIDTH +: IN_WIDTH] = bus.in_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) begin
      r_beat_cnt  <= '0;
      r_asm       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_blk_cnt   <= '0;
      r_done      <= 1'b0;
      r_strb_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_asm <= w_block;
        if (bus.in_strb_i != '1) begin
          r_strb_err <= 1'b1;
        end
        if (w_last) begin
          r_beat_cnt <= '0;
          r_out_data <= w_block;
        end else begin
          r_beat_cnt <= r_beat_cnt + c_BCW'(1);
        end
      end

      if (w_accept && w_last) begin
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (w_xfer) begin
        r_blk_cnt <= w_blk_next;
        if (w_done_hit) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid & bus.enable_i;
  assign bus.out_data_o  = r_out_data;
  assign bus.blk_cnt_o   = r_blk_cnt;
  assign bus.done_o      = r_done;
  assign bus.strb_err_o  = r_strb_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_word_packer                                                   |
// | Directed and random stimulus against a queue-based block model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_aes_word_packer;
  import aes_word_packer_pkg::*;

  localparam int IW = 32;
  localparam int OW = 128;
  localparam int CW = 16;

  logic clk;
  logic rst;

  aes_word_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus();

  aes_word_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: beats are collected in a queue; a full queue becomes a block.
  logic [31:0]  m_part[$];
  logic         m_ovalid = 1'b0;
  logic [127:0] m_odata  = '0;
  logic [15:0]  m_cnt    = '0;
  logic         m_done   = 1'b0;
  logic         m_serr   = 1'b0;
  bit           chk_en   = 1'b0;
  logic [127:0] out_log[$];

  function automatic logic exp_ready();
    return bus.enable_i & ~m_done & ~((m_part.size() == 3) & m_ovalid & ~bus.out_ready_i);
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit xfer;
    if (chk_en && !rst && !bus.clear_i && bus.out_valid_o && bus.out_ready_i)
      out_log.push_back(bus.out_data_o);
    if (rst || bus.clear_i) begin
      m_part.delete();
      m_ovalid = 1'b0;
      m_odata  = '0;
      m_cnt    = '0;
      m_done   = 1'b0;
      m_serr   = 1'b0;
      chk_en   = 1'b1;
    end else if (bus.enable_i) begin
      acc  = bus.in_valid_i && exp_ready();
      xfer = m_ovalid && bus.out_ready_i;
      if (xfer) begin
        m_cnt    = m_cnt + 16'd1;
        m_ovalid = 1'b0;
        if (bus.len_i != 0 && m_cnt == bus.len_i) m_done = 1'b1;
      end
      if (acc) begin
        if (bus.in_strb_i != 4'hF) m_serr = 1'b1;
        m_part.push_back(bus.in_data_i);
        if (m_part.size() == 4) begin
          for (int i = 0; i < 4; i++) m_odata[i*32 +: 32] = m_part[i];
          m_ovalid = 1'b1;
          m_part.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", bus.in_ready_o, exp_ready());
      check("out_valid", bus.out_valid_o, m_ovalid & bus.enable_i);
      if (m_ovalid & bus.enable_i) check("out_data", bus.out_data_o, m_odata);
      check("blk_cnt", bus.blk_cnt_o, m_cnt);
      check("done", bus.done_o, m_done);
      check("strb_err", bus.strb_err_o, m_serr);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] s, output int waited);
    waited = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    bus.in_strb_i  = s;
    forever begin
      @(negedge clk);
      if (bus.in_ready_o) break;
      waited++;
      if (waited > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL beat_timeout: got no in_ready after %0d cycles, required acceptance", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1;
    step(1);
    bus.clear_i = 1'b0;
    out_log.delete();
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  logic [31:0] v[8];
  int w;
  int stalls;

  initial begin
    rst = 1'b1;
    bus.clear_i = 1'b0;
    bus.enable_i = 1'b1;
    bus.len_i = '0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i = '0;
    bus.in_strb_i = 4'hF;
    bus.out_ready_i = 1'b1;
    step(3);
    rst = 1'b0;

    @(negedge clk);
    check("rst_blk_cnt", bus.blk_cnt_o, 0);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_in_ready", bus.in_ready_o, 1);
    step(1);

    // Basic packing order, LSW first.
    drive_beat(32'h00112233, 4'hF, w);
    drive_beat(32'h44556677, 4'hF, w);
    drive_beat(32'h8899AABB, 4'hF, w);
    drive_beat(32'hCCDDEEFF, 4'hF, w);
    @(negedge clk);
    check("basic_valid", bus.out_valid_o, 1);
    check("basic_data", bus.out_data_o, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    check("basic_model", m_odata, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    step(1);

    // Bounded job of two blocks, streamed back to back.
    do_clear();
    bus.len_i = 16'd2;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'h1000_0000 + i, 4'hF, w);
      stalls += w;
    end
    step(1);
    @(negedge clk);
    check("job_stalls", stalls, 0);
    check("job_blk_cnt", bus.blk_cnt_o, 2);
    check("job_done", bus.done_o, 1);
    check("job_in_ready", bus.in_ready_o, 0);
    check("job_blocks", out_log.size(), 2);
    check("job_model_cnt", m_cnt, 2);
    step(1);

    // Backpressure: first block held, three more beats taken, fourth refused.
    do_clear();
    bus.len_i = '0;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) v[i] = 32'hA000_0000 | (i * 32'h0101);
    stalls = 0;
    for (int i = 0; i < 7; i++) begin
      drive_beat(v[i], 4'hF, w);
      stalls += w;
    end
    check("bp_stalls", stalls, 0);
    bus.in_valid_i = 1'b1;
    bus.in_data_i = v[7];
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready_o, 0);
      check("bp_hold", bus.out_data_o, pack4(v[0], v[1], v[2], v[3]));
    end
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    drive_beat(v[7], 4'hF, w);
    step(3);
    check("bp_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check("bp_blk0", out_log[0], pack4(v[0], v[1], v[2], v[3]));
      check("bp_blk1", out_log[1], pack4(v[4], v[5], v[6], v[7]));
    end

    // Reset mid-block discards the partial beats.
    do_clear();
    drive_beat(32'hDEAD0000, 4'hF, w);
    drive_beat(32'hDEAD0001, 4'hF, w);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(32'h5000_0000 + i, 4'hF, w);
    step(2);
    check("rst_mid_count", out_log.size(), 1);
    if (out_log.size() == 1)
      check("rst_mid_blk", out_log[0], pack4(32'h50000000, 32'h50000001, 32'h50000002, 32'h50000003));

    // Bad strobe is sticky until clear.
    do_clear();
    drive_beat(32'h11111111, 4'hF, w);
    drive_beat(32'h22222222, 4'b0111, w);
    @(negedge clk);
    check("strb_set", bus.strb_err_o, 1);
    step(1);
    drive_beat(32'h33333333, 4'hF, w);
    drive_beat(32'h44444444, 4'hF, w);
    step(2);
    check("strb_sticky", bus.strb_err_o, 1);
    if (out_log.size() >= 1)
      check("strb_data", out_log[0], pack4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444));
    do_clear();
    @(negedge clk);
    check("strb_cleared", bus.strb_err_o, 0);
    step(1);

    // Enable low freezes everything mid-block.
    drive_beat(32'h70000000, 4'hF, w);
    drive_beat(32'h70000001, 4'hF, w);
    bus.in_valid_i = 1'b1;
    bus.in_data_i = 32'h70000002;
    bus.enable_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("en_in_ready", bus.in_ready_o, 0);
      check("en_out_valid", bus.out_valid_o, 0);
    end
    @(posedge clk);
    #1;
    bus.enable_i = 1'b1;
    drive_beat(32'h70000002, 4'hF, w);
    drive_beat(32'h70000003, 4'hF, w);
    step(2);
    check("en_count", out_log.size(), 1);
    if (out_log.size() == 1)
      check("en_blk", out_log[0], pack4(32'h70000000, 32'h70000001, 32'h70000002, 32'h70000003));

    // Random traffic against the model.
    do_clear();
    bus.len_i = 16'(3);
    for (int c = 0; c < 3000; c++) begin
      bus.enable_i    = ($urandom % 8) != 0;
      bus.in_valid_i  = ($urandom % 4) != 0;
      bus.in_data_i   = $urandom;
      bus.in_strb_i   = (($urandom % 16) == 0) ? 4'($urandom) : 4'hF;
      bus.out_ready_i = ($urandom % 3) != 0;
      bus.clear_i     = ($urandom % 150) == 0;
      rst             = ($urandom % 600) == 0;
      if ((c % 400) == 0) bus.len_i = 16'($urandom_range(0, 6));
      step(1);
    end
    bus.clear_i = 1'b0;
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.enable_i = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
